fpu_issue_seq: RTL
==================

Name: fpu_issue_seq

Overview:
Parametrised multi-cycle sequencer for floating-point instructions inside the execute stage. It accepts one FP operation per enable/done handshake and presents registered operands to the external FP units (fadd, fmul, finv, fsqrt, ftoi, itof, floor). It waits a per-unit, parameter-set latency, then captures the selected result and issues a one-cycle register write-back. It also keeps sticky overflow/underflow flags and reports illegal opcodes.

Parameters:
W, 32, data width of operands and results
RW, 5, register index width
CNT_W, 4, latency counter width; every LAT_* must be < 2**CNT_W
LAT_FADD, 1, pipeline depth of fadd unit (cycles)
LAT_FMUL, 1, pipeline depth of fmul unit
LAT_FINV, 2, pipeline depth of finv unit
LAT_FSQRT, 2, pipeline depth of fsqrt unit
LAT_CONV, 0, depth of ftoi/itof/floor (0 = combinational)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  request; sampled only while idle
fop  in  3  0 fadd, 1 fmul, 2 finv, 3 fsqrt, 4 ftoi, 5 itof, 6 floor, 7 illegal
src_a  in  W  first operand (fs)
src_b  in  W  second operand (ft)
rd_no  in  RW  destination register index
busy  out  1  high whenever not IDLE
done  out  1  one-cycle completion pulse
illegal  out  1  one-cycle pulse with done for fop=7
unit_a  out  W  registered operand to units (fs)
unit_b  out  W  registered operand to units (ft)
fadd_d, fmul_d, finv_d, sqrt_d, ftoi_d, itof_d, floor_d  in  W each  unit results
fadd_of, fmul_of, fmul_uf, finv_of, finv_uf  in  1 each  unit exception flags
wenable  out  1  register write strobe
wfmode  out  1  1 = FP register file, 0 = integer file
wreg  out  RW  write index
wdata  out  W  write data
exc_of  out  1  sticky overflow
exc_uf  out  1  sticky underflow
exc_clr  in  1  clears sticky flags

Behaviour:
- Reset: state IDLE; busy, done, illegal, wenable, wfmode, exc_of, exc_uf = 0; unit_a, unit_b, wreg, wdata = 0. Reset mid-operation drops the operation with no done and no write.
- States: IDLE, WAIT.
- IDLE, enable=1 at edge E0 (accept): latch unit_a<=src_a, unit_b<=src_b, op, rd_no. Load cnt with the op's latency (ftoi/itof/floor use LAT_CONV; illegal uses 0). Go to WAIT.
- WAIT, cnt!=0: decrement cnt.
- WAIT, cnt==0 (capture edge = E0+L+1): set done=1. For a legal op also set wenable=1, wreg=latched rd, wdata=selected result, wfmode=0 for ftoi and 1 otherwise. For fop=7 set illegal=1 with wenable=0. Return to IDLE.
- done, wenable and illegal are high for exactly the one cycle after the capture edge. wreg, wdata and wfmode hold their values until the next capture.
- Back-to-back: enable sampled in the cycle done is high is accepted. Peak throughput is one op per L+2 cycles.
- enable while busy is ignored; there is no queue. fop, src_* and rd_no are don't-care outside the accept edge.
- Exceptions: at the capture edge, OR the op's flags into the sticky flags. fadd uses fadd_of; fmul uses fmul_of and fmul_uf; finv uses finv_of and finv_uf; other ops use none. exc_clr clears both flags. If set and clear land on the same edge, set wins.
- unit_a and unit_b stay stable from the accept edge until the next accept.

Test Plan:
- fadd, LAT_FADD=1, src_a=0x3F800000, src_b=0x40000000, rd_no=3, bench fadd returns 0x40400000: busy for 2 cycles; at E0+2 done=wenable=1, wreg=3, wfmode=1, wdata=0x40400000.
- ftoi, LAT_CONV=0, src_a=0x40490FDB, ftoi_d=3, rd_no=8: done at E0+1, wfmode=0, wreg=8, wdata=3.
- finv (L=2) accepted; enable pulsed with fadd during WAIT; then fadd issued in the done cycle: only one finv write; fadd accepted, with its done 3 cycles later.
- fop=7, rd_no=5: done=1 and illegal=1 at E0+1, wenable=0, sticky flags unchanged.
- fmul with fmul_of=1 at capture: exc_of=1 persists over following ops. exc_clr on the same edge as a new fadd_of: exc_of stays 1. exc_clr alone: exc_of=0.
- fsqrt accepted, rst=1 at E0+1 for one cycle: no done or wenable ever, all outputs 0, next enable accepted normally.

Source files
------------

// File: rtl/fpu_issue_seq.sv
// Multi-cycle issue sequencer for the execute-stage FP units.
// Accepts one FP op per enable/done handshake, holds its operands steady for
// the external units, waits the unit's fixed latency, then captures the result
// and issues a single-cycle register write-back. Keeps sticky OF/UF flags.
//
// Handshake: while idle (busy=0) a high enable on a rising edge accepts the op
// presented on fop/src_a/src_b/rd_no; those inputs are ignored at every other
// edge. done pulses for exactly one cycle when the op retires, and enable may
// already be high in that cycle to start the next op.
module fpu_issue_seq #(
    parameter int W         = 32,
    parameter int RW        = 5,
    parameter int CNT_W     = 4,
    parameter int LAT_FADD  = 1,
    parameter int LAT_FMUL  = 1,
    parameter int LAT_FINV  = 2,
    parameter int LAT_FSQRT = 2,
    parameter int LAT_CONV  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [2:0]    fop,
    input  logic [W-1:0]  src_a,
    input  logic [W-1:0]  src_b,
    input  logic [RW-1:0] rd_no,
    output logic          busy,
    output logic          done,
    output logic          illegal,
    output logic [W-1:0]  unit_a,
    output logic [W-1:0]  unit_b,
    input  logic [W-1:0]  fadd_d,
    input  logic [W-1:0]  fmul_d,
    input  logic [W-1:0]  finv_d,
    input  logic [W-1:0]  sqrt_d,
    input  logic [W-1:0]  ftoi_d,
    input  logic [W-1:0]  itof_d,
    input  logic [W-1:0]  floor_d,
    input  logic          fadd_of,
    input  logic          fmul_of,
    input  logic          fmul_uf,
    input  logic          finv_of,
    input  logic          finv_uf,
    output logic          wenable,
    output logic          wfmode,
    output logic [RW-1:0] wreg,
    output logic [W-1:0]  wdata,
    output logic          exc_of,
    output logic          exc_uf,
    input  logic          exc_clr
);

    localparam logic [2:0] OP_FADD  = 3'd0;
    localparam logic [2:0] OP_FMUL  = 3'd1;
    localparam logic [2:0] OP_FINV  = 3'd2;
    localparam logic [2:0] OP_FSQRT = 3'd3;
    localparam logic [2:0] OP_FTOI  = 3'd4;
    localparam logic [2:0] OP_ITOF  = 3'd5;
    localparam logic [2:0] OP_FLOOR = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [2:0]        op;
    logic [RW-1:0]     rd;
    logic              accept;
    logic              capture;
    logic [W-1:0]      sel_data;
    logic              sel_of;
    logic              sel_uf;

    // Cycles to wait in WAIT before the unit result is valid; illegal ops retire at once.
    function automatic logic [CNT_W-1:0] op_latency(input logic [2:0] f);
        case (f)
            OP_FADD:                    op_latency = CNT_W'(LAT_FADD);
            OP_FMUL:                    op_latency = CNT_W'(LAT_FMUL);
            OP_FINV:                    op_latency = CNT_W'(LAT_FINV);
            OP_FSQRT:                   op_latency = CNT_W'(LAT_FSQRT);
            OP_FTOI, OP_ITOF, OP_FLOOR: op_latency = CNT_W'(LAT_CONV);
            default:                    op_latency = '0;
        endcase
    endfunction

    assign busy = (state != IDLE);

    // Next-state logic: accept in IDLE, count down in WAIT, capture at zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    accept     = 1'b1;
                    cnt_next   = op_latency(fop);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result and exception selection for the latched op.
    always_comb begin
        sel_data = '0;
        sel_of   = 1'b0;
        sel_uf   = 1'b0;
        case (op)
            OP_FADD:  begin sel_data = fadd_d; sel_of = fadd_of; end
            OP_FMUL:  begin sel_data = fmul_d; sel_of = fmul_of; sel_uf = fmul_uf; end
            OP_FINV:  begin sel_data = finv_d; sel_of = finv_of; sel_uf = finv_uf; end
            OP_FSQRT: sel_data = sqrt_d;
            OP_FTOI:  sel_data = ftoi_d;
            OP_ITOF:  sel_data = itof_d;
            OP_FLOOR: sel_data = floor_d;
            default:  sel_data = '0;
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Operand/op latch; operands stay stable until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            unit_a <= '0;
            unit_b <= '0;
            op     <= '0;
            rd     <= '0;
        end else if (accept) begin
            unit_a <= src_a;
            unit_b <= src_b;
            op     <= fop;
            rd     <= rd_no;
        end
    end

    // Completion pulses and write-back; write fields hold until the next legal capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            illegal <= 1'b0;
            wenable <= 1'b0;
            wfmode  <= 1'b0;
            wreg    <= '0;
            wdata   <= '0;
        end else begin
            done    <= capture;
            illegal <= capture && (op == OP_ILL);
            wenable <= capture && (op != OP_ILL);
            if (capture && (op != OP_ILL)) begin
                wreg   <= rd;
                wdata  <= sel_data;
                wfmode <= (op != OP_FTOI);
            end
        end
    end

    // Sticky exception flags; a set on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_of <= 1'b0;
            exc_uf <= 1'b0;
        end else begin
            exc_of <= (exc_of & ~exc_clr) | (capture & sel_of);
            exc_uf <= (exc_uf & ~exc_clr) | (capture & sel_uf);
        end
    end

endmodule
